// File: rtl/mdu_controller.sv
// HI/LO multiply-divide sequencer: fixed-latency multiply, 32-cycle restoring divide.
// Define MDU_FAST_MUL_EN to commit MULT/MULTU results at the acceptance edge.
module mdu_controller #(
    parameter int MUL_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [63:0] prod;
    logic [31:0] rem, quo, dvsr, dz_val;
    logic        q_neg, r_neg, dz;

    logic        accept, is_signed;
    logic [63:0] mul_a, mul_b, mul_p;
    logic [31:0] rs_abs, rt_abs;
    logic [32:0] shifted, diff;

    assign busy      = (state != S_IDLE);
    assign stall     = start && busy;
    assign accept    = start && !busy;
    assign is_signed = ~op[0];

    // Sign-extending to 64 bits lets one truncated multiply serve both MULT and MULTU.
    assign mul_a = {(is_signed ? {32{rs_val[31]}} : 32'b0), rs_val};
    assign mul_b = {(is_signed ? {32{rt_val[31]}} : 32'b0), rt_val};
    assign mul_p = mul_a * mul_b;

    assign rs_abs = (is_signed && rs_val[31]) ? -rs_val : rs_val;
    assign rt_abs = (is_signed && rt_val[31]) ? -rt_val : rt_val;

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvsr};

    always_comb begin
        mf_result = 32'b0;
        if (op == 3'd6) mf_result = hi;
        else if (op == 3'd7) mf_result = lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            dz_val <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            3'd0, 3'd1: begin
`ifdef MDU_FAST_MUL_EN
                                {hi, lo} <= mul_p;
                                done     <= 1'b1;
`else
                                prod  <= mul_p;
                                cnt   <= 6'(MUL_CYCLES - 1);
                                state <= S_MUL;
`endif
                            end
                            3'd2, 3'd3: begin
                                rem    <= '0;
                                quo    <= rs_abs;
                                dvsr   <= rt_abs;
                                q_neg  <= is_signed && (rs_val[31] ^ rt_val[31]);
                                r_neg  <= is_signed && rs_val[31];
                                dz     <= (rt_val == 32'b0);
                                dz_val <= rs_val;
                                cnt    <= 6'd31;
                                state  <= S_DIV;
                            end
                            3'd4:    hi <= rs_val;
                            3'd5:    lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt == 6'd0) begin
                        {hi, lo} <= prod;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                S_DIV: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    if (cnt == 6'd0) state <= S_FIX;
                    else cnt <= cnt - 6'd1;
                end
                default: begin
                    if (dz) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= dz_val;
                    end else begin
                        lo <= q_neg ? -quo : quo;
                        hi <= r_neg ? -rem : rem;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_controller.sv
// Scoreboard bench for mdu_controller: directed MDU ops, results checked on done.
module tb_mdu_controller;
    localparam int MULC = 5;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = MULC + 1;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        stall, busy, done;
    logic [31:0] hi, lo, mf_result;

    mdu_controller #(.MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
        .done(done), .hi(hi), .lo(lo), .mf_result(mf_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int lat, input bit push);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check({name, "_idle_timeout"}, 64'd1, 64'd0);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        if (push) sb.push_back('{hi: eh, lo: el, cyc: cyc + lat, name: name});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check({name, "_done_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        int n0, nst;
        #12;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, 1);
        drain("mult");
        issue("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 1);
        drain("divu");
        issue("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, 1);
        drain("div_neg");
        issue("div_zero", 3'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, DIV_LAT, 1);
        drain("div_zero");
        issue("divu_zero", 3'd3, 32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF, DIV_LAT, 1);
        drain("divu_zero");
        issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT, 1);
        drain("div_ovf");

        // MFLO presented in N+2 of a divide stalls until done.
        n0 = cyc;
        issue("div_stall", 3'd2, 32'd1000, 32'd10, 32'd0, 32'd100, DIV_LAT, 1);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd7;
        nst = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!stall) break;
            nst++;
            @(posedge clk); #1;
        end
        check("stall_cycles", 64'(nst), 64'd32);
        check("stall_release_cycle", 64'(cyc), 64'(n0 + 34));
        check("mflo_after_div", 64'(mf_result), 64'd100);
        @(posedge clk); #1;
        start = 1'b0;
        drain("div_stall");

        // MTHI then MFHI in the next cycle.
        start = 1'b1; op = 3'd4; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        op = 3'd6; rs_val = 32'd0;
        @(negedge clk);
        check("mfhi_result", 64'(mf_result), 64'hDEAD_BEEF);
        check("mfhi_busy", 64'(busy), 64'd0);
        check("mfhi_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd5; rs_val = 32'h0BAD_F00D;
        @(posedge clk); #1;
        op = 3'd7;
        @(negedge clk);
        check("mflo_result", 64'(mf_result), 64'h0BAD_F00D);
        @(posedge clk); #1;
        start = 1'b0;

        // Reset during divide iteration 10: no done may follow.
        issue("div_rst", 3'd3, 32'd100, 32'd7, 32'd0, 32'd0, DIV_LAT, 0);
        repeat (9) begin @(posedge clk); end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); end
        #1;
        check("rst_busy_later", 64'(busy), 64'd0);

        issue("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, MUL_LAT, 1);
`ifdef MDU_FAST_MUL_EN
        check("multu_busy", 64'(busy), 64'd0);
`else
        check("multu_busy", 64'(busy), 64'd1);
`endif
        drain("multu");
        repeat (3) begin @(posedge clk); end
        #1;
        check("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
